// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller blocks.
// Digits are 4-bit BCD; the seconds tens digit wraps to 5, all others to 9.
package microwave_pkg;

  typedef enum logic [1:0] {IDLE, LOADED, RUNNING, PAUSED} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  // Value a digit takes when it borrows; index 0 is seconds ones, 3 is minutes tens.
  function automatic bcd_t borrow_value(input int idx);
    return (idx == 1) ? SEC_TENS_MAX : BCD_MAX;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler. It counts only while run is high and holds otherwise,
// so a paused countdown resumes without losing or gaining a partial second.
module sec_tick_gen #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/cook_timer.sv
// BCD MM:SS countdown timer: keypad entry while idle/loaded, one-second countdown
// while the magnetron latch enables it, and an expiry level/pulse for the controller.
module cook_timer
  import microwave_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse
);

  state_t state_q, state_d;
  bcd_t   digit_q [4];
  bcd_t   digit_d [4];
  bcd_t   shift_val [4];
  bcd_t   dec_val [4];
  logic   done_pulse_q, done_pulse_d;
  logic   tick, run, restart;
  logic   key_ok, shift_zero, dec_zero;

  // The prescaler advances on every enabled cycle once a countdown has started,
  // including the cycle that resumes from a pause.
  assign run     = enable && ((state_q == RUNNING) || (state_q == PAUSED));
  assign restart = clear || ((state_q == LOADED) && enable);

  sec_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .run    (run),
    .restart(restart),
    .tick   (tick)
  );

  assign key_ok = key_valid && !enable && (key_digit <= BCD_MAX);

  assign shift_val[0] = key_digit;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_shift
      assign shift_val[gi] = digit_q[gi-1];
    end
  endgenerate

  assign shift_zero = (shift_val[0] == '0) && (shift_val[1] == '0) &&
                      (shift_val[2] == '0) && (shift_val[3] == '0);

  // Borrow ripples up from seconds ones; only a zero digit wraps and passes it on.
  always_comb begin
    logic borrow;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec_val[i] = digit_q[i];
      if (borrow) begin
        if (digit_q[i] == '0) begin
          dec_val[i] = borrow_value(i);
        end else begin
          dec_val[i] = digit_q[i] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
  end

  assign dec_zero = (dec_val[0] == '0) && (dec_val[1] == '0) &&
                    (dec_val[2] == '0) && (dec_val[3] == '0);

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    done_pulse_d = 1'b0;
    if (clear) begin
      for (int i = 0; i < 4; i++) begin
        digit_d[i] = '0;
      end
      state_d = IDLE;
    end else if (tick) begin
      digit_d = dec_val;
      if (dec_zero) begin
        state_d      = IDLE;
        done_pulse_d = 1'b1;
      end else begin
        state_d = RUNNING;
      end
    end else begin
      case (state_q)
        IDLE, LOADED: begin
          if ((state_q == LOADED) && enable) begin
            state_d = RUNNING;
          end else if (key_ok) begin
            digit_d = shift_val;
            state_d = shift_zero ? IDLE : LOADED;
          end
        end
        RUNNING: if (!enable) state_d = PAUSED;
        PAUSED:  if (enable)  state_d = RUNNING;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      done_pulse_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      done_pulse_q <= done_pulse_d;
      digit_q      <= digit_d;
    end
  end

  assign sec_ones   = digit_q[0];
  assign sec_tens   = digit_q[1];
  assign min_ones   = digit_q[2];
  assign min_tens   = digit_q[3];
  assign timer_done = (digit_q[0] == '0) && (digit_q[1] == '0) &&
                      (digit_q[2] == '0) && (digit_q[3] == '0);
  assign done_pulse = done_pulse_q;

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- BCD MM:SS countdown timer for the microwave controller.
- Accepts keypad digits while the magnetron is off and counts down one second at a time while enabled by the magnetron latch.
- Drives the `timer_done` input of the start/stop logic control, which resets the latch when time expires.
- Sits directly upstream of that control block. It also supplies the four display digits.

Parameters:
- TICK_DIV, 100000000: clock cycles per one-second tick. Legal range is 2 or more; benches use 4.

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- enable  input  1  magnetron-on level from the S/R latch. Countdown runs only while high.
- clear  input  1  synchronous clear, active high. Highest priority.
- key_valid  input  1  one-cycle strobe; key_digit is valid in the same cycle.
- key_digit  input  4  keypad digit. Only 0-9 is accepted; 10-15 is ignored.
- min_tens  output  4  BCD minutes, tens digit.
- min_ones  output  4  BCD minutes, ones digit.
- sec_tens  output  4  BCD seconds, tens digit.
- sec_ones  output  4  BCD seconds, ones digit.
- timer_done  output  1  level: high whenever all four digits are zero.
- done_pulse  output  1  one-cycle pulse on the clk edge at which a running count reaches 00:00.

Behaviour:
- Reset (async, resetn low):
  - All digits 0; prescaler 0; state IDLE.
  - timer_done=1, done_pulse=0.
  - Reset mid-countdown aborts immediately.
- States: IDLE (count zero), LOADED (nonzero, never started or re-armed), RUNNING, PAUSED.
- Priority per cycle: clear > tick/decrement > key entry.
- clear (any state):
  - Digits go to 0, prescaler to 0, state to IDLE, done_pulse=0.
  - A key or tick in the same cycle is discarded.
- Key entry (IDLE/LOADED only, enable low, key_digit <= 9):
  - Shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
  - The old min_tens is discarded.
  - Next state is LOADED if the result is nonzero, otherwise IDLE.
  - Keys in RUNNING/PAUSED, or with enable high, are ignored.
- LOADED + enable -> RUNNING, with prescaler cleared to 0.
- IDLE + enable: stays IDLE. timer_done=1 holds the control block in reset.
- RUNNING:
  - Prescaler counts 0..TICK_DIV-1.
  - The tick fires on the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - First decrement lands TICK_DIV cycles after entering RUNNING.
- Decrement (BCD borrow chain):
  - sec_ones 0 -> 9 with borrow.
  - sec_tens 0 -> 5 with borrow.
  - min_ones 0 -> 9 with borrow.
  - min_tens decrements.
  - Entered seconds above 59 (e.g. 00:99) count down normally until a borrow occurs.
- Expiry: when a decrement yields 00:00, the state goes to IDLE, done_pulse=1 for that one cycle, and timer_done rises on the same edge.
- RUNNING + enable low -> PAUSED, with the prescaler value held.
  - If enable falls in a tick cycle, no decrement occurs; decrement requires enable high in that cycle.
- PAUSED + enable high -> RUNNING. The prescaler resumes from its held value, so there is no lost or extra partial second.
- timer_done is combinational from the digit registers (count==0). It is glitch-free because the digits are registered.
- Digit outputs are registered and always reflect the current count.

Decomposition:
- Shared package microwave_pkg holds:
  - state enum {IDLE, LOADED, RUNNING, PAUSED};
  - a 4-bit bcd_t typedef;
  - constants BCD_MAX=9 and SEC_TENS_MAX=5.
- One sub-module, sec_tick_gen:
  - parameter TICK_DIV;
  - inputs clk, resetn, run, restart;
  - output tick;
  - holds its count when run is low.
- BCD decrement and key shift stay inline in cook_timer.

Test Plan:
- Reset -> all digits 0, timer_done=1, done_pulse=0. Key 0xC with enable low -> digits unchanged.
- Keys 1,3,0 then enable=1 (TICK_DIV=4) -> display 01:30, timer_done=0; 4 cycles later 01:29. From 01:00, the next tick gives 00:59.
- Load 00:01, enable -> after 4 cycles 00:00, done_pulse high exactly 1 cycle, timer_done=1. Enable held high afterwards -> no further change.
- Running at 00:10 with prescaler=2: drop enable for 10 cycles, then raise it -> 00:09 appears exactly 2 cycles after re-enable. Keys during the pause are ignored.
- Keys 1,2,3,4,5 -> 23:45. Clear asserted with key_valid and a tick in the same cycle -> 00:00, state IDLE, key discarded.
- Async resetn pulse mid-count at 05:00 -> immediate 00:00 and timer_done=1 without a clock edge.
